imem_loader: RTL
================

# imem_loader

Boot-time instruction loader that sits directly upstream of the single-cycle MIPS-lite core's byte-wide instruction memory. It accepts a framed byte stream over a valid/ready handshake and writes the bytes into the 8-bit instruction memory in big-endian order, matching the core's `{imem[pc], imem[pc+1], imem[pc+2], imem[pc+3]}` fetch. It verifies an XOR checksum and then releases the core via `cpu_run`. While `cpu_run` is low, the core's PC must be held at 0.

## Interface
- `MEM_BYTES`, default 32: instruction memory depth in bytes; must be a multiple of 4.
- `ADDR_W`, default 5: byte address width, log2(`MEM_BYTES`).
- `clk` input 1: single clock, all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse; begins a load from IDLE, or restarts from DONE/ERROR.
- `in_valid` input 1: stream byte valid.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `imem_we` output 1: instruction memory byte write enable.
- `imem_addr` output `ADDR_W`: byte write address.
- `imem_wdata` output 8: byte write data.
- `cpu_run` output 1: core released; high only in DONE.
- `load_err` output 1: sticky error flag; high only in ERROR.
- `words_loaded` output 4: number of 32-bit words committed in the last successful load.

## Operation
- Frame format: byte 0 = N, the word count. Then 4N payload bytes. Then 1 checksum byte equal to the XOR of all 4N payload bytes.
- Transfer rule: a byte transfers on a clock edge where `in_valid && in_ready`. `in_data` is ignored otherwise.
- FSM states: IDLE, COUNT, LOAD, CHECK, DONE, ERROR.
- **IDLE:** `in_ready` = 0. On `start`, go to COUNT.
- **COUNT:** `in_ready` = 1. On transfer:
  - If N = 0 or N > `MEM_BYTES`/4, go to ERROR.
  - Otherwise latch N, clear the byte counter and running XOR, and go to LOAD.
- **LOAD:** `in_ready` = 1. On transfer:
  - Write the byte to address = byte counter (0, 1, 2, …).
  - Fold the byte into the running XOR.
  - Increment the counter.
  - After byte 4N−1, go to CHECK.
- **CHECK:** `in_ready` = 1. On transfer:
  - If the byte equals the running XOR, go to DONE and set `words_loaded` = N.
  - Otherwise go to ERROR.
- **DONE:** `cpu_run` = 1. On `start`, go to COUNT with `cpu_run` = 0.
- **ERROR:** `load_err` = 1 and `cpu_run` = 0. On `start`, go to COUNT.
- `start` is ignored in COUNT, LOAD and CHECK.
- Bytes beyond 4N are never written. Memory above the loaded region keeps its previous contents.
- A failed checksum does not roll back memory already written; `cpu_run` simply stays low.
- Byte counter width is `ADDR_W`+1, so 4N = `MEM_BYTES` never wraps.

## Timing
- Reset values: FSM = IDLE, `in_ready` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0, `cpu_run` = 0, `load_err` = 0, `words_loaded` = 0.
- `in_ready` is a registered function of state only. It never depends on `in_valid` in the same cycle.
- Throughput: one byte per cycle when `in_valid` is held high. Stalls in `in_valid` are tolerated in any receiving state.
- Write latency: the write port (`imem_we`, `imem_addr`, `imem_wdata`) is registered. It is valid in the cycle after a LOAD transfer and held for exactly one cycle. `imem_we` = 0 otherwise.
- `cpu_run` rises in the cycle after the checksum transfer. By then the last payload byte's write has already been issued.
- Minimum frame of N=1 (6 bytes): `cpu_run` high 7 cycles after `start`, assuming continuous `in_valid`.
- Reset mid-load: all outputs return to reset values immediately (asynchronous). A partial memory image is left as-is. The core stays held.
- `start` coincident with a transfer in DONE/ERROR: the byte is not accepted (`in_ready` = 0 in those states), and the FSM moves to COUNT.

## Structure
- Shared package (`mips_lite_pkg`) holds:
  - the state enum `loader_state_t`;
  - constants `IMEM_BYTES` = 32 and `IMEM_ADDR_W` = 5, which the core also uses for its `imem` and `datmem` sizes.
- One sub-module, `xor_accum`: an 8-bit running-XOR register with clear and enable. It is kept separate so it can be reused for a future data-memory loader.
- Everything else (FSM, counter, write-port registers) is flat in `imem_loader`.

## Test plan
- **Good load, N=2:** after `start`, stream 02, 8C 01 00 00, 20 42 00 04, checksum 0x8C^0x01^0x20^0x42^0x04 = 0xEB.
  - Expect writes to addresses 0..7 with those bytes.
  - Expect `cpu_run` = 1 and `words_loaded` = 2.
  - Expect `load_err` = 0.
- **Bad checksum:** the same frame with checksum 0xEA.
  - Expect `load_err` = 1 and `cpu_run` = 0.
  - Addresses 0..7 hold the streamed bytes.
- **Illegal count:**
  - N=0 → `load_err` = 1, no `imem_we` pulses.
  - N=9 → `load_err` = 1, no `imem_we` pulses.
- **Full memory, N=8:** 32 payload bytes 00..1F, checksum 0x00.
  - Expect the last write at address 31 and no address wrap.
  - Expect `cpu_run` = 1.
- **Backpressure/stalls:** toggle `in_valid` randomly during a N=2 frame.
  - Expect an identical memory image.
  - Expect exactly 8 `imem_we` pulses.
- **Reset mid-LOAD:** assert `rst_n` = 0 after 3 payload bytes.
  - Expect all outputs at reset values.
  - Then `start` plus a good N=1 frame → `cpu_run` = 1.

Source files
------------

// File: rtl/mips_lite_pkg.sv
// Shared MIPS-lite definitions: memory geometry used by the core and the boot loader,
// plus the loader state encoding.
package mips_lite_pkg;

    localparam int IMEM_BYTES  = 32;
    localparam int IMEM_ADDR_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The master side is the stream source and memory; the slave side is the loader.
import mips_lite_pkg::*;

interface imem_loader_if #(
    parameter int ADDR_W = IMEM_ADDR_W
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/xor_accum.sv
// 8-bit running-XOR register; clear wins over enable.
import mips_lite_pkg::*;

module xor_accum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = 8'h00;
        end else if (en) begin
            acc_d = acc_q ^ din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 8'h00;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: receives a counted, XOR-checked byte frame, writes it big-endian
// into the byte-wide instruction memory and releases the core once the checksum matches.
import mips_lite_pkg::*;

module imem_loader #(
    parameter int MEM_BYTES = IMEM_BYTES,
    parameter int ADDR_W    = IMEM_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    imem_loader_if.slave        bus,
    output logic                cpu_run,
    output logic                load_err,
    output logic [3:0]          words_loaded
);

    localparam int         CNT_W     = ADDR_W + 1;
    localparam int         N_W       = ADDR_W - 1;
    localparam logic [7:0] MAX_WORDS = 8'(MEM_BYTES / 4);

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_W-1:0]    n_q, n_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              run_q, run_d;
    logic              err_q, err_d;
    logic [3:0]        words_q, words_d;

    logic              xfer;
    logic              xor_clr;
    logic              xor_en;
    logic [7:0]        xor_val;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  frame_bytes;

    assign xfer        = bus.in_valid && in_ready_q;
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign frame_bytes = {n_q, 2'b00};

    xor_accum u_xor (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (xor_clr),
        .en    (xor_en),
        .din   (bus.in_data),
        .acc   (xor_val)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        words_d = words_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        xor_clr = 1'b0;
        xor_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (xfer) begin
                    if (bus.in_data == 8'h00 || bus.in_data > MAX_WORDS) begin
                        state_d = ST_ERROR;
                    end else begin
                        n_d     = bus.in_data[N_W-1:0];
                        cnt_d   = '0;
                        xor_clr = 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = bus.in_data;
                    xor_en  = 1'b1;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == frame_bytes) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (xfer) begin
                    if (bus.in_data == xor_val) begin
                        words_d = 4'(n_q);
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (start) state_d = ST_COUNT;
            end
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are decoded from the next state so they register alongside it.
        in_ready_d = (state_d == ST_COUNT) || (state_d == ST_LOAD) || (state_d == ST_CHECK);
        run_d      = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            run_q      <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= 4'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            run_q      <= run_d;
            err_q      <= err_d;
            words_q    <= words_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_run        = run_q;
    assign load_err       = err_q;
    assign words_loaded   = words_q;

endmodule
